// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs feeding a 4-slot round-robin common data bus.
// Define CDB_BYPASS_EN to let an empty FIFO's incoming result go straight to the bus.
module cdb_arbiter #(
    parameter int NUM_FU = 6,
    parameter int DEPTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_FU-1:0]    fu_valid,
    output logic [NUM_FU-1:0]    fu_ready,
    input  logic [4*NUM_FU-1:0]  fu_index_flat,
    input  logic [16*NUM_FU-1:0] fu_value_flat,
    output logic [3:0]           cdb_valid_flat,
    output logic [15:0]          cdb_indices_flat,
    output logic [63:0]          cdb_values_flat
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int RW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;
    typedef logic [19:0] ent_t;

    ent_t             mem [NUM_FU][DEPTH];
    logic [PW-1:0]    rd [NUM_FU];
    logic [PW-1:0]    wr [NUM_FU];
    logic [2:0]       cnt [NUM_FU];
    ent_t             in_d [NUM_FU];
    ent_t             data [NUM_FU];
    logic [NUM_FU-1:0] nonempty, push, elig, grant, wen, pop;
    logic [RW-1:0]    rr_ptr, rr_next;
    logic [3:0]       sv;
    ent_t             sd [4];

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            nonempty[i] = cnt[i] != 3'd0;
            fu_ready[i] = rst_n && (cnt[i] < 3'(DEPTH));
            push[i]     = fu_valid[i] && fu_ready[i];
            in_d[i]     = {fu_index_flat[4*i+:4], fu_value_flat[16*i+:16]};
            data[i]     = nonempty[i] ? mem[i][rd[i]] : in_d[i];
        end
`ifdef CDB_BYPASS_EN
        elig = nonempty | push;
`else
        elig = nonempty;
`endif
    end

    // scan from rr_ptr, first four eligible FUs fill slots in scan order
    always_comb begin
        logic [RW:0] fi;
        logic [2:0]  n;
        grant   = '0;
        sv      = '0;
        rr_next = rr_ptr;
        n       = '0;
        fi      = '0;
        for (int s = 0; s < 4; s++) sd[s] = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            fi = {1'b0, rr_ptr} + (RW+1)'(k);
            fi = fi >= (RW+1)'(NUM_FU) ? fi - (RW+1)'(NUM_FU) : fi;
            if (elig[fi[RW-1:0]] && n < 3'd4) begin
                grant[fi[RW-1:0]] = 1'b1;
                sv[n[1:0]]        = 1'b1;
                sd[n[1:0]]        = data[fi[RW-1:0]];
                n                 = n + 3'd1;
                rr_next           = fi[RW-1:0] == RW'(NUM_FU-1) ? '0 : fi[RW-1:0] + 1'b1;
            end
        end
    end

    // a bypassed (granted while empty) result never enters its FIFO
    assign pop = grant & nonempty;
    assign wen = push & ~(grant & ~nonempty);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++)
            if (wen[i]) mem[i][wr[i]] <= in_d[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr           <= '0;
            cdb_valid_flat   <= '0;
            cdb_indices_flat <= '0;
            cdb_values_flat  <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                rd[i]  <= '0;
                wr[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            if (|grant) rr_ptr <= rr_next;
            for (int s = 0; s < 4; s++) begin
                cdb_valid_flat[3-s]          <= sv[s];
                cdb_indices_flat[4*(3-s)+:4] <= sd[s][19:16];
                cdb_values_flat[16*(3-s)+:16] <= sd[s][15:0];
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (wen[i]) wr[i] <= wr[i] == PW'(DEPTH-1) ? '0 : wr[i] + 1'b1;
                if (pop[i]) rd[i] <= rd[i] == PW'(DEPTH-1) ? '0 : rd[i] + 1'b1;
                cnt[i] <= cnt[i] + 3'(wen[i]) - 3'(pop[i]);
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random checks of cdb_arbiter against a queue-based model.
module tb_cdb_arbiter;
    localparam int N = 6;
    localparam int D = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   fu_valid = '0;
    logic [N-1:0]   fu_ready;
    logic [4*N-1:0] fu_index_flat = '0;
    logic [16*N-1:0] fu_value_flat = '0;
    logic [3:0]     cdb_valid_flat;
    logic [15:0]    cdb_indices_flat;
    logic [63:0]    cdb_values_flat;

    int checks = 0;
    int errors = 0;
    logic [19:0] q [N][$];
    int rr = 0;
    int seq = 0;
    logic saw_full = 1'b0;

    cdb_arbiter #(.NUM_FU(N), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_index_flat(fu_index_flat), .fu_value_flat(fu_value_flat),
        .cdb_valid_flat(cdb_valid_flat), .cdb_indices_flat(cdb_indices_flat),
        .cdb_values_flat(cdb_values_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) q[i].delete();
        rr = 0;
    endtask

    // one clock of stimulus: predict the bus from the FIFO queues, then advance them
    task automatic step(input logic [N-1:0] v, input logic [4*N-1:0] ix, input logic [16*N-1:0] vl);
        logic [N-1:0] rdy, gr;
        logic [3:0]   ev;
        logic [15:0]  ei;
        logic [63:0]  evl;
        logic [19:0]  d;
        logic         el;
        int n, f, rr_n, sz;
        fu_valid = v;
        fu_index_flat = ix;
        fu_value_flat = vl;
        #1;
        for (int i = 0; i < N; i++) rdy[i] = q[i].size() < D;
        if (rdy != '1) saw_full = 1'b1;
        chk("fu_ready", 64'(fu_ready), 64'(rdy));
        ev = '0; ei = '0; evl = '0; gr = '0; n = 0; rr_n = rr;
        for (int k = 0; k < N; k++) begin
            f = (rr + k) % N;
            el = q[f].size() > 0;
`ifdef CDB_BYPASS_EN
            el = el || (v[f] && rdy[f]);
`endif
            d = q[f].size() > 0 ? q[f][0] : {ix[4*f+:4], vl[16*f+:16]};
            if (el && n < 4) begin
                gr[f] = 1'b1;
                ev[3-n] = 1'b1;
                ei[4*(3-n)+:4] = d[19:16];
                evl[16*(3-n)+:16] = d[15:0];
                n++;
                rr_n = (f + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(cdb_valid_flat), 64'(ev));
        chk("cdb_indices", 64'(cdb_indices_flat), 64'(ei));
        chk("cdb_values", cdb_values_flat, evl);
        for (int i = 0; i < N; i++) begin
            sz = q[i].size();
            if (gr[i] && sz > 0) void'(q[i].pop_front());
            if (v[i] && rdy[i] && !(gr[i] && sz == 0)) q[i].push_back({ix[4*i+:4], vl[16*i+:16]});
        end
        if (n > 0) rr = rr_n;
    endtask

    task automatic rand_step(input logic [N-1:0] v);
        logic [4*N-1:0]  ix;
        logic [16*N-1:0] vl;
        for (int i = 0; i < N; i++) begin
            ix[4*i+:4] = 4'($urandom_range(0, 15));
            vl[16*i+:16] = {3'(i), 13'(seq)};
            seq++;
        end
        step(v, ix, vl);
    endtask

    task automatic idx_step(input logic [N-1:0] v);
        logic [4*N-1:0]  ix;
        logic [16*N-1:0] vl;
        for (int i = 0; i < N; i++) begin
            ix[4*i+:4] = 4'(i);
            vl[16*i+:16] = 16'hA000 + 16'(i);
        end
        step(v, ix, vl);
    endtask

    initial begin
        #12;
        chk("reset_valid", 64'(cdb_valid_flat), 64'd0);
        chk("reset_values", cdb_values_flat, 64'd0);
        chk("reset_ready", 64'(fu_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // single FU0 result
        step(6'b000001, 24'h5, 96'h1234);
        step('0, '0, '0);
`ifndef CDB_BYPASS_EN
        chk("t1_valid", 64'(cdb_valid_flat), 64'h8);
        chk("t1_index", 64'(cdb_indices_flat[15:12]), 64'h5);
        chk("t1_value", 64'(cdb_values_flat[63:48]), 64'h1234);
`endif
        step('0, '0, '0);

        // all six at once, then FU5/FU1 ordering from rr_ptr=4 and rr_ptr=2
        model_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        idx_step('1);
        idx_step('0);
`ifndef CDB_BYPASS_EN
        chk("t2_b1", 64'(cdb_indices_flat), 64'h0123);
`endif
        idx_step('0);
`ifndef CDB_BYPASS_EN
        chk("t2_b2", 64'({cdb_valid_flat, cdb_indices_flat}), 64'hC4500);
`endif
        idx_step(6'b001111);
        idx_step(6'b100010);
        idx_step(6'b001010);
`ifndef CDB_BYPASS_EN
        chk("t4_order", 64'({cdb_valid_flat, cdb_indices_flat}), 64'hC5100);
`endif
        idx_step('0);
`ifndef CDB_BYPASS_EN
        chk("t4_rr2", 64'({cdb_valid_flat, cdb_indices_flat}), 64'hC3100);
`endif

        // saturating load then random traffic
        for (int c = 0; c < 20; c++) rand_step('1);
        chk("t3_backpressure", 64'(saw_full), 64'd1);
        for (int c = 0; c < 200; c++) rand_step(N'($urandom));

        // asynchronous reset while FIFOs hold entries
        for (int c = 0; c < 3; c++) rand_step('1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 64'(cdb_valid_flat), 64'd0);
        chk("t5_ready_low", 64'(fu_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_ready_high", 64'(fu_ready), 64'h3F);
        for (int c = 0; c < 3; c++) rand_step('0);
        for (int c = 0; c < 100; c++) rand_step(N'($urandom));
        for (int c = 0; c < 6; c++) rand_step('0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
